// File: rtl/load_store_unit.sv
// RV32I memory-access stage: validates func3/alignment, runs one word-wide bus
// transaction with byte enables, and returns an extended load or store completion.
module load_store_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_store_i,
  input  logic [2:0]      req_func3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_ack_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  output logic            rsp_valid_o,
  output logic            rsp_we_o,
  output logic [4:0]      rsp_rd_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_misaligned_o,
  output logic            rsp_illegal_o,
  output logic            rsp_bus_err_o
);

  localparam int unsigned CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        func3_q, func3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [4:0]        rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q, rsp_we_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_mis_q, rsp_mis_d;
  logic              rsp_ill_q, rsp_ill_d;
  logic              rsp_berr_q, rsp_berr_d;

  logic              illegal_c, misaligned_c, timeout_c;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   wdata_c, shifted_c, load_c;

  // Request decode: func3 legality, alignment, lane enables and replicated store data
  always_comb begin
    if (req_store_i) illegal_c = (req_func3_i != 3'b000) && (req_func3_i != 3'b001) &&
                                 (req_func3_i != 3'b010);
    else             illegal_c = (req_func3_i == 3'b011) || (req_func3_i[2:1] == 2'b11);
    misaligned_c = ((req_func3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                   ((req_func3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    case (req_func3_i[1:0])
      2'b00:   be_c = 4'b0001 << req_addr_i[1:0];
      2'b01:   be_c = 4'b0011 << req_addr_i[1:0];
      default: be_c = 4'b1111;
    endcase
    case (req_func3_i[1:0])
      2'b00:   wdata_c = {4{req_wdata_i[7:0]}};
      2'b01:   wdata_c = {2{req_wdata_i[15:0]}};
      default: wdata_c = req_wdata_i;
    endcase
  end

  // Load lane extraction from the returned word
  always_comb begin
    shifted_c = bus_rdata_i >> {addr_lo_q, 3'b000};
    case (func3_q)
      3'b000:  load_c = {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
      3'b100:  load_c = {{(XLEN-8){1'b0}}, shifted_c[7:0]};
      3'b001:  load_c = {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
      3'b101:  load_c = {{(XLEN-16){1'b0}}, shifted_c[15:0]};
      default: load_c = bus_rdata_i;
    endcase
  end

  assign timeout_c = (BUS_TIMEOUT != 0) && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    func3_d     = func3_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_ill_d   = rsp_ill_q;
    rsp_berr_d  = rsp_berr_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          store_d   = req_store_i;
          func3_d   = req_func3_i;
          addr_lo_d = req_addr_i[1:0];
          rd_d      = req_rd_i;
          cnt_d     = '0;
          if (illegal_c || misaligned_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rd_d    = req_rd_i;
            rsp_ill_d   = illegal_c;
            rsp_mis_d   = !illegal_c;
          end else begin
            state_d     = BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = req_store_i;
            bus_addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
            bus_be_d    = be_c;
            bus_wdata_d = wdata_c;
          end
        end
      end
      BUS: begin
        // An ack in the timeout cycle takes priority over the error
        if (bus_ack_i) begin
          state_d     = RESP;
          bus_req_d   = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = rd_q;
          rsp_we_d    = !store_q && (rd_q != 5'd0);
          rsp_data_d  = store_q ? '0 : load_c;
        end else if (timeout_c) begin
          state_d     = RESP;
          bus_req_d   = 1'b0;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = rd_q;
          rsp_berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        rsp_we_d    = 1'b0;
        rsp_rd_d    = '0;
        rsp_data_d  = '0;
        rsp_mis_d   = 1'b0;
        rsp_ill_d   = 1'b0;
        rsp_berr_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      func3_q     <= '0;
      addr_lo_q   <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_data_q  <= '0;
      rsp_mis_q   <= 1'b0;
      rsp_ill_q   <= 1'b0;
      rsp_berr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      func3_q     <= func3_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_ill_q   <= rsp_ill_d;
      rsp_berr_q  <= rsp_berr_d;
    end
  end

  assign req_ready_o      = (state_q == IDLE);
  assign bus_req_o        = bus_req_q;
  assign bus_we_o         = bus_we_q;
  assign bus_addr_o       = bus_addr_q;
  assign bus_be_o         = bus_be_q;
  assign bus_wdata_o      = bus_wdata_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_we_o         = rsp_we_q;
  assign rsp_rd_o         = rsp_rd_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_misaligned_o = rsp_mis_q;
  assign rsp_illegal_o    = rsp_ill_q;
  assign rsp_bus_err_o    = rsp_berr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: default-timeout instance plus a BUS_TIMEOUT=3 instance.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid2, req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata, bus_rdata;
  logic [4:0]  req_rd;
  logic        bus_ack, bus_ack2;

  logic        req_ready, bus_req, bus_we, rsp_valid, rsp_we, rsp_mis, rsp_ill, rsp_berr;
  logic [31:0] bus_addr, bus_wdata, rsp_data;
  logic [3:0]  bus_be;
  logic [4:0]  rsp_rd;

  logic        req_ready2, bus_req2, bus_we2, rsp_valid2, rsp_we2, rsp_mis2, rsp_ill2, rsp_berr2;
  logic [31:0] bus_addr2, bus_wdata2, rsp_data2;
  logic [3:0]  bus_be2;
  logic [4:0]  rsp_rd2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_store_i(req_store), .req_func3_i(req_func3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack),
    .bus_rdata_i(bus_rdata), .rsp_valid_o(rsp_valid), .rsp_we_o(rsp_we), .rsp_rd_o(rsp_rd),
    .rsp_data_o(rsp_data), .rsp_misaligned_o(rsp_mis), .rsp_illegal_o(rsp_ill),
    .rsp_bus_err_o(rsp_berr)
  );

  load_store_unit #(.XLEN(32), .BUS_TIMEOUT(3)) dut_to (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid2), .req_ready_o(req_ready2),
    .req_store_i(req_store), .req_func3_i(req_func3), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rd_i(req_rd), .bus_req_o(bus_req2), .bus_we_o(bus_we2),
    .bus_addr_o(bus_addr2), .bus_be_o(bus_be2), .bus_wdata_o(bus_wdata2), .bus_ack_i(bus_ack2),
    .bus_rdata_i(bus_rdata), .rsp_valid_o(rsp_valid2), .rsp_we_o(rsp_we2), .rsp_rd_o(rsp_rd2),
    .rsp_data_o(rsp_data2), .rsp_misaligned_o(rsp_mis2), .rsp_illegal_o(rsp_ill2),
    .rsp_bus_err_o(rsp_berr2)
  );

  // Present one request for a single cycle; returns #1 after the accepting edge
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input bit second);
    req_store = st; req_func3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    if (second) req_valid2 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if ({bus_addr, bus_wdata, bus_be} !== 68'd0) begin errors++; $display("FAIL reset_bus_fields: got %h expected 0", {bus_addr, bus_wdata, bus_be}); end
    checks++; if ({rsp_data, rsp_rd, rsp_we, rsp_mis, rsp_ill, rsp_berr} !== 41'd0) begin errors++; $display("FAIL reset_rsp_fields: got %h expected 0", {rsp_data, rsp_rd, rsp_we, rsp_mis, rsp_ill, rsp_berr}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1'b0);
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0) begin errors++; $display("FAIL lw_req: got req=%b we=%b expected 1/0", bus_req, bus_we); end
    checks++; if (bus_be !== 4'b1111 || bus_addr !== 32'h100) begin errors++; $display("FAIL lw_be_addr: got %b %h expected 1111 00000100", bus_be, bus_addr); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lw_ready_busy: got %b expected 0", req_ready); end
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(posedge clk); #1; bus_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rsp: got v=%b d=%h expected 1 deadbeef", rsp_valid, rsp_data); end
    checks++; if (rsp_we !== 1'b1 || rsp_rd !== 5'd5 || {rsp_mis, rsp_ill, rsp_berr} !== 3'b000) begin errors++; $display("FAIL lw_rsp_flags: got we=%b rd=%0d err=%b expected 1 5 000", rsp_we, rsp_rd, {rsp_mis, rsp_ill, rsp_berr}); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL lw_req_drop: got %b expected 0", bus_req); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || req_ready !== 1'b1) begin errors++; $display("FAIL lw_rsp_clear: got v=%b d=%h rdy=%b expected 0 0 1", rsp_valid, rsp_data, req_ready); end
  endtask

  task automatic test_sub_word_loads();
    logic [2:0]  f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] ad [5] = '{32'h103, 32'h103, 32'h102, 32'h000, 32'h101};
    logic [4:0]  rd [5] = '{5'd3, 5'd4, 5'd6, 5'd0, 5'd7};
    logic [31:0] rw [5] = '{32'h80123456, 32'h80123456, 32'h80011234, 32'h1234F00F, 32'h00007F00};
    logic [3:0]  be [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010};
    logic [31:0] ed [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00F, 32'h0000007F};
    logic        ew [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0, rd[i], 1'b0);
      checks++; if (bus_be !== be[i] || bus_addr !== {ad[i][31:2], 2'b00}) begin errors++; $display("FAIL ld%0d_be_addr: got %b %h expected %b %h", i, bus_be, bus_addr, be[i], {ad[i][31:2], 2'b00}); end
      bus_ack = 1'b1; bus_rdata = rw[i];
      @(posedge clk); #1; bus_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== ed[i]) begin errors++; $display("FAIL ld%0d_data: got v=%b %h expected 1 %h", i, rsp_valid, rsp_data, ed[i]); end
      checks++; if (rsp_we !== ew[i]) begin errors++; $display("FAIL ld%0d_we: got %b expected %b", i, rsp_we, ew[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3 [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] ad [3] = '{32'h202, 32'h101, 32'h204};
    logic [31:0] wd [3] = '{32'h1234ABCD, 32'hAABBCC77, 32'hCAFEF00D};
    logic [3:0]  be [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ew [3] = '{32'hABCDABCD, 32'h77777777, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, f3[i], ad[i], wd[i], 5'd9, 1'b0);
      checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== be[i]) begin errors++; $display("FAIL st%0d_ctrl: got req=%b we=%b be=%b expected 1 1 %b", i, bus_req, bus_we, bus_be, be[i]); end
      checks++; if (bus_wdata !== ew[i] || bus_addr !== {ad[i][31:2], 2'b00}) begin errors++; $display("FAIL st%0d_data: got %h @%h expected %h", i, bus_wdata, bus_addr, ew[i]); end
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      @(posedge clk); #1; bus_ack = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL st%0d_rsp: got v=%b we=%b d=%h expected 1 0 0", i, rsp_valid, rsp_we, rsp_data); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_faults();
    logic        st [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3 [6] = '{3'b010, 3'b100, 3'b011, 3'b101, 3'b001, 3'b010};
    logic [31:0] ad [6] = '{32'h101, 32'h000, 32'h001, 32'h103, 32'h201, 32'h202};
    logic        ei [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        em [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      issue(st[i], f3[i], ad[i], 32'h55, 5'd11, 1'b0);
      checks++; if (bus_req !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL flt%0d_timing: got req=%b v=%b expected 0 1", i, bus_req, rsp_valid); end
      checks++; if (rsp_ill !== ei[i] || rsp_mis !== em[i] || rsp_berr !== 1'b0) begin errors++; $display("FAIL flt%0d_flags: got ill=%b mis=%b berr=%b expected %b %b 0", i, rsp_ill, rsp_mis, rsp_berr, ei[i], em[i]); end
      checks++; if (rsp_we !== 1'b0 || rsp_data !== 32'h0) begin errors++; $display("FAIL flt%0d_we: got we=%b d=%h expected 0 0", i, rsp_we, rsp_data); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || bus_req !== 1'b0 || rsp_ill !== 1'b0 || rsp_mis !== 1'b0) begin errors++; $display("FAIL flt%0d_clear: got v=%b req=%b expected 0 0", i, rsp_valid, bus_req); end
    end
  endtask

  task automatic test_idle_ack();
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1; bus_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL idle_ack: got v=%b req=%b rdy=%b expected 0 0 1", rsp_valid, bus_req, req_ready); end
  endtask

  task automatic test_delayed_ack();
    issue(1'b1, 3'b000, 32'h303, 32'h000000A5, 5'd1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h300 || bus_be !== 4'b1000 || bus_wdata !== 32'hA5A5A5A5 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL hold_c%0d: got req=%b we=%b a=%h be=%b wd=%h v=%b expected 1 1 00000300 1000 a5a5a5a5 0", c, bus_req, bus_we, bus_addr, bus_be, bus_wdata, rsp_valid);
      end
      if (c == 5) bus_ack = 1'b1;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_berr !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL hold_done: got v=%b berr=%b req=%b expected 1 0 0", rsp_valid, rsp_berr, bus_req); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus_req2 !== 1'b1 || rsp_valid2 !== 1'b0) begin errors++; $display("FAIL to_wait%0d: got req=%b v=%b expected 1 0", c, bus_req2, rsp_valid2); end
      @(posedge clk); #1;
    end
    checks++; if (bus_req2 !== 1'b0 || rsp_valid2 !== 1'b1 || rsp_berr2 !== 1'b1) begin errors++; $display("FAIL to_err: got req=%b v=%b berr=%b expected 0 1 1", bus_req2, rsp_valid2, rsp_berr2); end
    checks++; if (rsp_we2 !== 1'b0 || rsp_data2 !== 32'h0) begin errors++; $display("FAIL to_err_data: got we=%b d=%h expected 0 0", rsp_we2, rsp_data2); end
    @(posedge clk); #1;
    checks++; if (rsp_valid2 !== 1'b0 || rsp_berr2 !== 1'b0 || req_ready2 !== 1'b1) begin errors++; $display("FAIL to_clear: got v=%b berr=%b rdy=%b expected 0 0 1", rsp_valid2, rsp_berr2, req_ready2); end
    issue(1'b0, 3'b001, 32'h402, 32'h0, 5'd8, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_ack2 = 1'b1; bus_rdata = 32'h7FFF0000;
    @(posedge clk); #1; bus_ack2 = 1'b0;
    checks++; if (rsp_valid2 !== 1'b1 || rsp_berr2 !== 1'b0 || rsp_data2 !== 32'h00007FFF || rsp_we2 !== 1'b1) begin errors++; $display("FAIL to_ack_wins: got v=%b berr=%b d=%h we=%b expected 1 0 00007fff 1", rsp_valid2, rsp_berr2, rsp_data2, rsp_we2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_bus();
    issue(1'b0, 3'b010, 32'h500, 32'h0, 5'd4, 1'b0);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstbus_pre: got %b expected 1", bus_req); end
    rst_n = 1'b0; #1;
    checks++; if (bus_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstbus_abort: got req=%b v=%b rdy=%b expected 0 0 1", bus_req, rsp_valid, req_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h11111111;
    @(posedge clk); #1; bus_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstbus_no_rsp: got v=%b rdy=%b expected 0 1", rsp_valid, req_ready); end
    issue(1'b0, 3'b010, 32'h600, 32'h0, 5'd12, 1'b0);
    bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    @(posedge clk); #1; bus_ack = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0BADF00D || rsp_rd !== 5'd12) begin errors++; $display("FAIL rstbus_next: got v=%b d=%h rd=%0d expected 1 0badf00d 12", rsp_valid, rsp_data, rsp_rd); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_valid2 = 1'b0; req_store = 1'b0; req_func3 = 3'b000;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    bus_ack = 1'b0; bus_ack2 = 1'b0; bus_rdata = '0;
    test_reset();
    test_lw();
    test_sub_word_loads();
    test_stores();
    test_faults();
    test_idle_ack();
    test_delayed_ack();
    test_timeout();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage of the RV32I core, directly downstream of the decoder that classifies LOAD/STORE opcodes and their func3 encodings. It accepts one decoded load or store at a time and checks the func3 code and address alignment. It then runs a single word-wide bus transaction with byte enables and returns a sign- or zero-extended load result, or a store completion, to writeback. Only one access is in flight at a time; there is no pipelining across requests.

Parameters:
XLEN, 32, data and address width (only 32 is supported)
BUS_TIMEOUT, 255, cycles to wait for bus_ack before aborting with a bus error; 0 disables the timeout

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  decoded LOAD/STORE request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_store  in  1  1 = STORE opcode, 0 = LOAD opcode
req_func3  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  effective byte address
req_wdata  in  32  store data (rs2)
req_rd  in  5  destination register for loads
bus_req  out  1  bus transaction request
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  transaction complete; rdata valid in same cycle
bus_rdata  in  32  read word
rsp_valid  out  1  one-cycle completion pulse
rsp_we  out  1  write rsp_data to rsp_rd (successful loads with rd != 0)
rsp_rd  out  5  destination register
rsp_data  out  32  extended load value; 0 for stores and errors
rsp_misaligned  out  1  address misaligned for width
rsp_illegal  out  1  illegal func3 for the operation
rsp_bus_err  out  1  timeout expired before bus_ack

Behaviour:
- Reset (asynchronous, rst_n low): state goes to IDLE. All registered outputs go to 0 (bus_req, bus_we, bus_addr, bus_be, bus_wdata, rsp_*). The timeout counter goes to 0. req_ready is 1 whenever state is IDLE, including during reset.
- FSM states: IDLE, BUS, RESP.
- IDLE: when req_valid is high, latch all req_* fields.
  - Illegal func3: loads with 011/110/111; stores with anything other than 000/001/010. Go to RESP with rsp_illegal=1.
  - Otherwise misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. Go to RESP with rsp_misaligned=1.
  - If both apply, only rsp_illegal is set.
  - Otherwise go to BUS.
  - bus_req is never asserted for a faulting request.
- BUS: bus_req=1. bus_we, bus_addr, bus_be and bus_wdata are held stable until bus_ack is sampled high.
  - Byte enables: B/BU = 4'b0001<<addr[1:0]; H/HU = 4'b0011<<addr[1:0]; W = 4'b1111.
  - Store data: SB replicates byte[7:0] into all four lanes; SH replicates [15:0] into both halves; SW passes data through.
  - On bus_ack: latch the extracted load lane (byte at addr[1:0]*8, or half at addr[1]*16). Sign-extend for B/H, zero-extend for BU/HU. Clear bus_req and go to RESP.
  - The timeout counter increments each BUS cycle without bus_ack. When it reaches BUS_TIMEOUT, drop bus_req, set rsp_bus_err=1 and go to RESP.
  - A bus_ack arriving in the same cycle as the timeout wins; no error is reported.
- RESP: rsp_valid=1 for exactly one cycle with the error flags and data, then return to IDLE.
  - rsp_we=1 only for a successful load with rd≠0.
  - rsp_* outputs return to 0 in the following cycle.
- Latency: request accepted in cycle N; bus_req is high from N+1; if bus_ack arrives in N+1, rsp_valid is high in N+2. Faulting requests: rsp_valid in N+1.
- bus_ack outside BUS is ignored.
- Reset mid-BUS aborts the access immediately; no rsp_valid is produced for it.

Test Plan:
- LW addr 0x100, ack next cycle, rdata 0xDEADBEEF → bus_be 1111, bus_addr 0x100, rsp_valid 2 cycles after accept, rsp_data 0xDEADBEEF, rsp_we=1.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80xxxxxx → rsp_data 0xFFFFFF80 and 0x00000080 respectively; be 1000.
- SH addr 0x202, wdata 0x1234ABCD → bus_we=1, be 1100, bus_wdata 0xABCDABCD, rsp_we=0, rsp_data 0.
- LW addr 0x101 → no bus_req, rsp_misaligned=1 one cycle after accept. Store with func3 100 → rsp_illegal=1.
- bus_ack delayed 5 cycles → bus_* outputs stable for all 6 BUS cycles. BUS_TIMEOUT=3 with no ack → bus_req high 3 cycles, then rsp_bus_err=1.
- rst_n pulled low during BUS → bus_req and rsp_valid drop to 0 immediately; after release, req_ready=1 and the next LW completes normally.
